// File: rtl/mshr_line_buffer.sv
// Refill line buffers, one per MSHR: beat-granular fill tracking, replay reads, line-complete pulse.
// Optional macro MSHR_LB_BYPASS_EN forwards same-cycle write data to a matching read.
module mshr_line_buffer #(
  parameter int DATA_BITS = 64,
  parameter int N_ENTRIES = 4,
  parameter int N_BEATS   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_write_valid,
  output logic                         io_write_ready,
  input  logic [1:0]                   io_write_bits_id,
  input  logic [1:0]                   io_write_bits_offset,
  input  logic [DATA_BITS-1:0]         io_write_bits_data,
  input  logic                         io_read_valid,
  output logic                         io_read_ready,
  input  logic [1:0]                   io_read_bits_id,
  input  logic [1:0]                   io_read_bits_offset,
  output logic                         io_resp_valid,
  output logic [DATA_BITS-1:0]         io_resp_data,
  input  logic                         io_clear_valid,
  input  logic [1:0]                   io_clear_id,
  output logic                         io_line_done_valid,
  output logic [1:0]                   io_line_done_id,
  output logic [N_ENTRIES*N_BEATS-1:0] io_beat_valid
);
  localparam int N_LOCS = N_ENTRIES * N_BEATS;
  localparam int IDX_W  = (N_LOCS > 1) ? $clog2(N_LOCS) : 1;

  logic [DATA_BITS-1:0] mem [N_LOCS];
  logic [N_LOCS-1:0]    beat_valid_reg;
  logic [N_LOCS-1:0]    beat_valid_next;
  logic [N_LOCS-1:0]    beat_set;
  logic [N_LOCS-1:0]    clear_mask;
  logic [N_ENTRIES-1:0] fill_hit;
  logic [IDX_W-1:0]     write_idx;
  logic [IDX_W-1:0]     read_idx;
  logic                 write_fire;
  logic                 read_fire;
  logic                 bypass_hit;
  logic [1:0]           done_id;

  logic                 resp_valid_reg;
  logic [DATA_BITS-1:0] resp_data_reg;
  logic                 line_done_valid_reg;
  logic [1:0]           line_done_id_reg;

  assign write_idx = IDX_W'(io_write_bits_id) * IDX_W'(N_BEATS) + IDX_W'(io_write_bits_offset);
  assign read_idx  = IDX_W'(io_read_bits_id) * IDX_W'(N_BEATS) + IDX_W'(io_read_bits_offset);

  // A retiring entry refuses refill beats so the clear cannot be undone in the same cycle.
  assign io_write_ready = !(io_clear_valid && (io_clear_id == io_write_bits_id));
  assign write_fire     = io_write_valid && io_write_ready;

`ifdef MSHR_LB_BYPASS_EN
  assign bypass_hit = write_fire && (write_idx == read_idx);
`else
  assign bypass_hit = 1'b0;
`endif

  assign io_read_ready = beat_valid_reg[read_idx] || bypass_hit;
  assign read_fire     = io_read_valid && io_read_ready;

  always_comb begin
    beat_set = '0;
    if (write_fire) beat_set[write_idx] = 1'b1;
  end

  generate
    for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
      logic [N_BEATS-1:0] old_beats;
      logic [N_BEATS-1:0] new_beats;
      assign clear_mask[gi*N_BEATS +: N_BEATS] = {N_BEATS{io_clear_valid && (io_clear_id == 2'(gi))}};
      assign old_beats    = beat_valid_reg[gi*N_BEATS +: N_BEATS];
      assign new_beats    = old_beats | beat_set[gi*N_BEATS +: N_BEATS];
      // Only the transition to full counts, so overwriting a full line stays silent.
      assign fill_hit[gi] = (old_beats != {N_BEATS{1'b1}}) && (new_beats == {N_BEATS{1'b1}});
    end
  endgenerate

  assign beat_valid_next = (beat_valid_reg | beat_set) & ~clear_mask;

  always_comb begin
    done_id = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (fill_hit[i]) done_id = 2'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (write_fire) mem[write_idx] <= io_write_bits_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_valid_reg      <= '0;
      resp_valid_reg      <= 1'b0;
      resp_data_reg       <= '0;
      line_done_valid_reg <= 1'b0;
      line_done_id_reg    <= '0;
    end else begin
      beat_valid_reg      <= beat_valid_next;
      resp_valid_reg      <= read_fire;
      resp_data_reg       <= read_fire ? (bypass_hit ? io_write_bits_data : mem[read_idx]) : '0;
      line_done_valid_reg <= |fill_hit;
      line_done_id_reg    <= done_id;
    end
  end

  // Masking with reset kills a response already in flight when reset arrives.
  assign io_resp_valid      = resp_valid_reg && !reset;
  assign io_resp_data       = reset ? '0 : resp_data_reg;
  assign io_line_done_valid = line_done_valid_reg && !reset;
  assign io_line_done_id    = reset ? 2'b00 : line_done_id_reg;
  assign io_beat_valid      = beat_valid_reg;
endmodule

// File: tb/tb_mshr_line_buffer.sv
// Scoreboard bench for mshr_line_buffer: directed stimulus pushes expected responses, a monitor checks them.
module tb_mshr_line_buffer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_write_valid = 1'b0;
  logic        io_write_ready;
  logic [1:0]  io_write_bits_id = '0;
  logic [1:0]  io_write_bits_offset = '0;
  logic [63:0] io_write_bits_data = '0;
  logic        io_read_valid = 1'b0;
  logic        io_read_ready;
  logic [1:0]  io_read_bits_id = '0;
  logic [1:0]  io_read_bits_offset = '0;
  logic        io_resp_valid;
  logic [63:0] io_resp_data;
  logic        io_clear_valid = 1'b0;
  logic [1:0]  io_clear_id = '0;
  logic        io_line_done_valid;
  logic [1:0]  io_line_done_id;
  logic [15:0] io_beat_valid;

  mshr_line_buffer #(.DATA_BITS(64), .N_ENTRIES(4), .N_BEATS(4)) dut (
    .clock(clock), .reset(reset),
    .io_write_valid(io_write_valid), .io_write_ready(io_write_ready),
    .io_write_bits_id(io_write_bits_id), .io_write_bits_offset(io_write_bits_offset),
    .io_write_bits_data(io_write_bits_data),
    .io_read_valid(io_read_valid), .io_read_ready(io_read_ready),
    .io_read_bits_id(io_read_bits_id), .io_read_bits_offset(io_read_bits_offset),
    .io_resp_valid(io_resp_valid), .io_resp_data(io_resp_data),
    .io_clear_valid(io_clear_valid), .io_clear_id(io_clear_id),
    .io_line_done_valid(io_line_done_valid), .io_line_done_id(io_line_done_id),
    .io_beat_valid(io_beat_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } exp_t;

  exp_t resp_q[$];
  exp_t done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: each output event must match the head of its queue in the expected cycle.
  always @(negedge clock) begin
    exp_t e;
    while (resp_q.size() > 0 && resp_q[0].cyc < cyc) begin
      e = resp_q.pop_front();
      checks++; errors++;
      $display("FAIL resp_missing cycle=%0d actual=none required=%h", e.cyc, e.val);
    end
    if (io_resp_valid) begin
      if (resp_q.size() == 0 || resp_q[0].cyc != cyc) begin
        checks++; errors++;
        $display("FAIL resp_unexpected cycle=%0d actual=%h required=none", cyc, io_resp_data);
      end else begin
        e = resp_q.pop_front();
        check("resp_data", io_resp_data, e.val);
        $display("resp cycle=%0d data=%h expected=%h", cyc, io_resp_data, e.val);
      end
    end else begin
      check("resp_idle_zero", io_resp_data, 64'h0);
    end
    while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
      e = done_q.pop_front();
      checks++; errors++;
      $display("FAIL line_done_missing cycle=%0d actual=none required=%h", e.cyc, e.val);
    end
    if (io_line_done_valid) begin
      if (done_q.size() == 0 || done_q[0].cyc != cyc) begin
        checks++; errors++;
        $display("FAIL line_done_unexpected cycle=%0d actual=%0d required=none", cyc, io_line_done_id);
      end else begin
        e = done_q.pop_front();
        check("line_done_id", 64'(io_line_done_id), e.val);
        $display("line_done cycle=%0d id=%0d expected=%0d", cyc, io_line_done_id, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    reset = 1'b0;
    io_write_valid = 1'b0;
    io_read_valid = 1'b0;
    io_clear_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] id, input logic [1:0] off, input logic [63:0] data);
    io_write_valid = 1'b1;
    io_write_bits_id = id;
    io_write_bits_offset = off;
    io_write_bits_data = data;
  endtask

  task automatic rd(input logic [1:0] id, input logic [1:0] off);
    io_read_valid = 1'b1;
    io_read_bits_id = id;
    io_read_bits_offset = off;
  endtask

  task automatic clr(input logic [1:0] id);
    io_clear_valid = 1'b1;
    io_clear_id = id;
  endtask

  task automatic exp_resp(input logic [63:0] val);
    resp_q.push_back('{cyc + 1, val});
  endtask

  task automatic exp_done(input logic [63:0] id);
    done_q.push_back('{cyc + 1, id});
  endtask

  initial begin
    repeat (2) @(posedge clock);
    tick(); #1;
    check("reset_beat_valid", 64'(io_beat_valid), 64'h0);
    check("reset_resp_valid", 64'(io_resp_valid), 64'h0);
    check("reset_line_done", 64'(io_line_done_valid), 64'h0);
    check("reset_line_done_id", 64'(io_line_done_id), 64'h0);

    // Fill entry 1.
    for (int i = 0; i < 4; i++) begin
      tick(); wr(2'd1, 2'(i), 64'hA0 + 64'(i)); #1;
      check("fill1_write_ready", 64'(io_write_ready), 64'h1);
      if (i == 3) exp_done(64'd1);
    end
    tick(); #1;
    check("fill1_beats", 64'(io_beat_valid[7:4]), 64'hF);
    rd(2'd1, 2'd2); #1;
    check("read12_ready", 64'(io_read_ready), 64'h1);
    exp_resp(64'hA2);
    tick(); rd(2'd2, 2'd0); #1;
    check("read20_not_ready", 64'(io_read_ready), 64'h0);
    for (int i = 0; i < 4; i++) begin
      if (i != 2) begin
        tick(); rd(2'd1, 2'(i)); #1;
        check("b2b_read_ready", 64'(io_read_ready), 64'h1);
        exp_resp(64'hA0 + 64'(i));
      end
    end

    // Overwrite a full line: no second line_done.
    tick(); wr(2'd1, 2'd0, 64'hB0); #1;
    check("rewrite_ready", 64'(io_write_ready), 64'h1);
    tick(); rd(2'd1, 2'd0); #1;
    check("rewrite_read_ready", 64'(io_read_ready), 64'h1);
    exp_resp(64'hB0);

    // Clear with colliding write and read on the same entry.
    tick(); clr(2'd1); wr(2'd1, 2'd0, 64'hCC); rd(2'd1, 2'd3); #1;
    check("clear_write_refused", 64'(io_write_ready), 64'h0);
    check("clear_read_ready", 64'(io_read_ready), 64'h1);
    exp_resp(64'hA3);
    tick(); #1;
    check("cleared_beats", 64'(io_beat_valid[7:4]), 64'h0);
    clr(2'd2); wr(2'd0, 2'd0, 64'h10); rd(2'd1, 2'd3); #1;
    check("other_write_ready", 64'(io_write_ready), 64'h1);
    check("cleared_read_not_ready", 64'(io_read_ready), 64'h0);
    tick(); #1;
    check("beats_after_id0", 64'(io_beat_valid), 64'h0001);
    wr(2'd2, 2'd0, 64'h20); rd(2'd0, 2'd0); #1;
    check("indep_write_ready", 64'(io_write_ready), 64'h1);
    check("indep_read_ready", 64'(io_read_ready), 64'h1);
    exp_resp(64'h10);
    tick(); #1;
    check("beats_indep", 64'(io_beat_valid), 64'h0101);

    // Same-cycle write and read of an empty beat.
    wr(2'd3, 2'd1, 64'h55); rd(2'd3, 2'd1); #1;
    check("bypass_write_ready", 64'(io_write_ready), 64'h1);
`ifdef MSHR_LB_BYPASS_EN
    check("bypass_read_ready", 64'(io_read_ready), 64'h1);
    exp_resp(64'h55);
`else
    check("bypass_read_ready", 64'(io_read_ready), 64'h0);
`endif
    tick(); rd(2'd3, 2'd1); #1;
    check("beats_id3", 64'(io_beat_valid), 64'h2101);
    check("id3_read_ready", 64'(io_read_ready), 64'h1);
    exp_resp(64'h55);

    // Reset mid-fill of entry 0, with a read in flight and writes during reset.
    tick(); clr(2'd0);
    tick(); wr(2'd0, 2'd0, 64'hD0);
    tick(); wr(2'd0, 2'd1, 64'hD1); rd(2'd3, 2'd1); #1;
    check("pre_reset_read_ready", 64'(io_read_ready), 64'h1);
    tick(); reset = 1'b1; wr(2'd0, 2'd2, 64'hD2);
    tick(); reset = 1'b1; wr(2'd0, 2'd3, 64'hD3);
    tick(); #1;
    check("post_reset_beats", 64'(io_beat_valid), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick(); wr(2'd0, 2'(i), 64'hE0 + 64'(i)); #1;
      check("refill0_write_ready", 64'(io_write_ready), 64'h1);
      if (i == 3) exp_done(64'd0);
    end
    tick(); #1;
    check("refill0_beats", 64'(io_beat_valid), 64'h000F);
    rd(2'd0, 2'd3);
    exp_resp(64'hE3);
    repeat (4) tick();
    check("resp_queue_drained", 64'(resp_q.size()), 64'h0);
    check("done_queue_drained", 64'(done_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mshr_line_buffer.md
MSHR_LINE_BUFFER -- requirements
Module: mshr_line_buffer

Interface
REQ-001 SHALL have parameters: DATA_BITS, default 64, width of one refill beat; N_ENTRIES, default 4, number of line buffers (one per MSHR); N_BEATS, default 4, beats per cache line.
REQ-002 SHALL have ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- io_write_valid  in  1  refill beat write request
- io_write_ready  out  1  write accepted
- io_write_bits_id  in  2  target entry
- io_write_bits_offset  in  2  target beat
- io_write_bits_data  in  DATA_BITS  beat data
- io_read_valid  in  1  replay read request
- io_read_ready  out  1  read accepted
- io_read_bits_id  in  2  entry
- io_read_bits_offset  in  2  beat
- io_resp_valid  out  1  read data valid
- io_resp_data  out  DATA_BITS  read data
- io_clear_valid  in  1  free entry (MSHR retire)
- io_clear_id  in  2  entry to free
- io_line_done_valid  out  1  entry became fully filled
- io_line_done_id  out  2  which entry
- io_beat_valid  out  N_ENTRIES*N_BEATS  per-beat valid map; bit id*N_BEATS+offset

Function
REQ-003 SHALL hold a data array of N_ENTRIES x N_BEATS x DATA_BITS and a beat-valid flop per entry/beat.
REQ-004 SHALL drive io_write_ready = !(io_clear_valid && io_clear_id == io_write_bits_id); otherwise 1.
REQ-005 Write fire (valid && ready) SHALL store data and set the beat-valid bit at the next clock edge.
REQ-006 Write to an already-valid beat SHALL overwrite data and SHALL NOT produce a second line_done.
REQ-007 When a write sets the last missing beat of an entry, io_line_done_valid SHALL pulse high for exactly one cycle, the cycle after the write fires, with io_line_done_id = that entry.
REQ-008 io_read_ready SHALL be 1 iff the addressed beat-valid bit is set (bypass case per REQ-016).
REQ-009 Read fire SHALL produce io_resp_valid = 1 exactly one cycle later with io_resp_data = addressed beat; io_resp_valid = 0 in all other cycles.
REQ-010 Back-to-back reads SHALL be accepted every cycle, one response per cycle, in order.
REQ-011 Clear SHALL zero all beat-valid bits of io_clear_id at the next edge; data array is not cleared.
REQ-012 Clear and read to the same entry in one cycle: read readiness uses pre-clear state; an accepted read SHALL return the stored data.
REQ-013 Clear and write to the same entry in one cycle: write is refused (REQ-004); clear wins.
REQ-014 Writes and reads to different entries/beats in the same cycle SHALL proceed independently.
REQ-015 io_resp_data SHALL be 0 when io_resp_valid = 0.

Reset
REQ-017 Reset SHALL clear all beat-valid bits, io_resp_valid, io_line_done_valid (0), io_line_done_id (0), io_resp_data (0); data array contents unspecified.
REQ-018 Reset asserted mid-fill SHALL discard partial lines; no line_done SHALL be emitted for writes fired during the reset cycle; a read accepted the cycle before reset SHALL NOT produce a response during or after reset.

Configuration
REQ-016 Macro MSHR_LB_BYPASS_EN: defined -> a read to the same id/offset as a same-cycle write fire SHALL be ready and its response SHALL carry the write data; undefined -> such a read is ready only if the beat was already valid, and returns the old data.

Verification
REQ-019 Write id=1 offsets 0..3 with data 0xA0..0xA3 on 4 consecutive cycles -> line_done_valid=1, id=1 in cycle 5 only; io_beat_valid[7:4]=4'hF.
REQ-020 Read id=1 offset 2 after REQ-019 -> read_ready=1, resp_valid next cycle with data 0xA2; read id=2 offset 0 (unfilled) -> read_ready=0.
REQ-021 Rewrite id=1 offset 0 with 0xB0 -> no line_done; subsequent read returns 0xB0.
REQ-022 Clear id=1 while writing id=1 offset 0 -> write_ready=0; next cycle io_beat_valid[7:4]=0; write to id=0 same cycle accepted.
REQ-023 Same-cycle write id=3 offset 1 data 0x55 and read id=3 offset 1 on empty entry -> with MSHR_LB_BYPASS_EN: read_ready=1, resp 0x55; without: read_ready=0.
REQ-024 Assert reset after 2 of 4 beats of id=0 -> io_beat_valid=0, no line_done; then 4 fresh beats -> single line_done for id=0.
